// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable 50%-duty integer clock divider.
// New divisors are swapped in only at an output-period boundary.
module clk_div_prog #(
  parameter int DIV_W   = 4,
  parameter int DIV_RST = 2,
  parameter int CNT_W   = DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [DIV_W-1:0] div_cur,
  output logic             period_start,
  output logic             clk_out
);

  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_RST - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_pend_div;
  logic             r_pend;
  logic             r_clkp;
  logic             r_clkn;
  logic             r_ps;
  logic             r_err;

  logic [DIV_W-1:0] w_div_m1;
  logic [DIV_W-1:0] w_div_nxt;
  logic [DIV_W-1:0] w_half_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;
  logic             w_swap;
  logic             w_accept;
  logic             w_zero;
  logic             w_load;
  logic             w_byp;
  logic             w_odd;
  logic             w_even;

  assign w_div_m1   = r_div - DIV_W'(1);
  assign w_last     = (r_cnt == CNT_W'(w_div_m1));
  assign w_cnt_nxt  = w_last ? '0 : r_cnt + CNT_W'(1);
  assign w_swap     = w_last & r_pend;
  assign w_div_nxt  = w_swap ? r_pend_div : r_div;
  assign w_half_nxt = w_div_nxt >> 1;

  assign w_accept = cfg_valid & ~r_pend;
  assign w_zero   = (cfg_div == '0);
  assign w_load   = w_accept & ~w_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= CNT_INIT;
      r_div      <= DIV_INIT;
      r_pend_div <= DIV_INIT;
      r_pend     <= 1'b0;
      r_clkp     <= 1'b0;
      r_ps       <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_div  <= w_div_nxt;
      // phase is judged against the divisor of the period being entered
      r_clkp <= (w_cnt_nxt < CNT_W'(w_half_nxt));
      r_ps   <= (w_cnt_nxt == '0);
      r_err  <= w_accept & w_zero;
      if (w_load) begin
        r_pend     <= 1'b1;
        r_pend_div <= cfg_div;
      end else if (w_swap) begin
        r_pend <= 1'b0;
      end
    end
  end

  // half-cycle delayed copy stretches odd-divisor high time by 0.5
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_clkn <= 1'b0;
    end else begin
      r_clkn <= r_clkp;
    end
  end

  assign w_byp  = (r_div == DIV_W'(1));
  assign w_odd  = r_div[0] & ~w_byp;
  assign w_even = ~r_div[0];

  always_comb begin
    clk_out = r_clkp;
    unique case (1'b1)
      w_byp:   clk_out = clk;
      w_odd:   clk_out = r_clkp | r_clkn;
      w_even:  clk_out = r_clkp;
      default: clk_out = r_clkp;
    endcase
  end

  assign cfg_ready    = ~r_pend;
  assign cfg_err      = r_err;
  assign div_cur      = r_div;
  assign period_start = r_ps;

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider. It divides by any value from 1 to 2^DIV_W-1.
- The output has 50% duty for both odd and even divisors.
- Divisor changes are glitch-free: a new divisor is applied only at an output-period boundary.
- Sits in the clock-generation area and feeds low-speed peripheral clocks. It replaces the fixed-parameter even/odd dividers.

Parameters:
DIV_W, 4, width of the divisor field; maximum divisor is 2^DIV_W-1 (15 at default)
DIV_RST, 2, divisor in effect after reset; legal range 1..2^DIV_W-1
CNT_W, DIV_W, width of the internal period counter

Ports:
clk  input  1  source clock; all state updates on rising edge except the clkn half-cycle register (falling edge)
rst  input  1  asynchronous, active-high reset
cfg_valid  input  1  request to load a new divisor
cfg_div  input  DIV_W  requested divisor; sampled when cfg_valid & cfg_ready
cfg_ready  output  1  high when no load is pending; a request is accepted only when cfg_valid & cfg_ready
cfg_err  output  1  one-cycle pulse when cfg_valid & cfg_ready & cfg_div==0; the request is dropped
div_cur  output  DIV_W  divisor currently generating clk_out
period_start  output  1  one-cycle pulse (clk domain), high during the first source cycle of every output period
clk_out  output  1  divided clock

Behaviour:
- Reset (async, any time, including mid-period or with a load pending):
  - Outputs: clk_out=0, cfg_ready=1, cfg_err=0, period_start=0, div_cur=DIV_RST.
  - Internal: cnt=DIV_RST-1, clkp=0, clkn=0, pend=0.
  - Clearing rst aborts any pending load.
- Counter (D = div_cur, H = D>>1):
  - Each rising edge: if cnt==D-1 then cnt<=0 (boundary), else cnt<=cnt+1.
  - The first rising edge after reset release is therefore a boundary.
- Phase registers:
  - clkp is registered on the rising edge as (cnt_next < H).
  - clkn <= clkp on every falling edge.
- Output select:
  - D==1: clk_out = clk (bypass).
  - D even: clk_out = clkp. High for D/2 source cycles.
  - D odd and >=3: clk_out = clkp | clkn. High for (D-1)/2 + 0.5 = D/2 source cycles.
- period_start is the registered (cnt_next==0). It is high for exactly one source cycle per output period, coinciding with the clk_out rising edge (D>=2).
- Load handshake:
  - On accept with cfg_div!=0: store the value in pend_div, set pend=1, cfg_ready=0 from the next cycle.
  - At the next boundary edge (cnt==D-1) with pend=1:
    - div_cur<=pend_div, cnt<=0, pend<=0.
    - clkp computed from the new D (1 if new D>=2).
    - cfg_ready returns to 1 the cycle after the boundary.
- Simultaneous events:
  - A request presented in the same cycle as a boundary while pend=1 is not accepted (cfg_ready=0).
  - If pend=0, a request accepted on a boundary edge takes effect at the following boundary, never the current one.
- Glitch-freedom:
  - In the last cycle of every period with D>=2, both clkp and clkn are 0, so the mode/divisor mux changes only while clk_out is low and clk is low.
  - Switching out of bypass (D=1): the new period starts on a rising edge with clkp=1. This gives no runt pulse.
- Width: cnt, div_cur and pend_div are CNT_W/DIV_W bits, unsigned. The comparisons cnt==D-1 and cnt_next<H are unsigned and never wrap, because cnt<=D-1 always holds.
- Loading the same divisor as div_cur is legal. It re-aligns nothing, and the period continues uninterrupted.

Test Plan:
- Reset then idle, DIV_RST=2 -> clk_out toggles every source cycle (period 2, high 1 cycle); period_start high on every other cycle; div_cur=2.
- Load 8 -> after the current period ends, clk_out period 8 cycles, high 4; cfg_ready low from accept until the cycle after the boundary.
- Load 7 -> period 7 cycles, high time 3.5 source cycles; measured duty 50% ±0; no pulse narrower than 3.5 cycles across the 8->7 switch.
- Load 1 then load 3 -> bypass: clk_out==clk; leaving bypass gives period 3, high 1.5 cycles; no glitch at either switch.
- cfg_div=0 with cfg_ready=1 -> cfg_err pulses one cycle, div_cur unchanged, cfg_ready stays 1. Also: a second cfg_valid while pend=1 -> ignored, and the first value is applied.
- Assert rst mid-period with a load pending (div 5 -> 6 pending) -> all outputs immediately at reset values, div_cur=DIV_RST; after release, the first rising edge starts a DIV_RST period and 6 is never applied.
